// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and constants for the key event generator.
// Per-key FSM state encoding, the action bit map of the key_on bus, and a
// helper that sizes the auto-repeat frame counter.
`timescale 1ns/1ps

package key_event_pkg;

   // IDLE/DELAY/REPEAT are used with auto-repeat; HELD replaces DELAY/REPEAT without it
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2,
      HELD   = 2'd3
   } key_state_t;

   // Bit positions of each game action on key_on; indices >= NUM_KEYS are absent
   localparam int unsigned P1_UP    = 0;
   localparam int unsigned P1_DOWN  = 1;
   localparam int unsigned P1_LEFT  = 2;
   localparam int unsigned P1_RIGHT = 3;
   localparam int unsigned P1_FIRE  = 4;
   localparam int unsigned P2_UP    = 5;
   localparam int unsigned P2_DOWN  = 6;
   localparam int unsigned P2_LEFT  = 7;
   localparam int unsigned P2_RIGHT = 8;
   localparam int unsigned P2_FIRE  = 9;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      if (a > b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

   // Counter must hold the larger reload value; it never reaches zero while counting
   function automatic int unsigned cnt_width(input int unsigned dly, input int unsigned rate);
      return $clog2(max_u(dly, rate) + 32'd1);
   endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// key_event_gen_if: key level input and event outputs of key_event_gen.
// master drives key_on and observes events; slave is the generator side.
`timescale 1ns/1ps

interface key_event_gen_if #(
   parameter int unsigned NUM_KEYS = 8
);
   logic [NUM_KEYS-1:0] key_on;
   logic [NUM_KEYS-1:0] key_held;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_release;
   logic                any_press;

   modport master (
      output key_on,
      input  key_held,
      input  key_press,
      input  key_release,
      input  any_press
   );

   modport slave (
      input  key_on,
      output key_held,
      output key_press,
      output key_release,
      output any_press
   );
endinterface

// File: rtl/key_event_cell.sv
// key_event_cell: one key's frame-sampled FSM with registered held level and
// one-cycle press/release pulses. press_next_o is the unregistered press
// condition so the top can register any_press in the same cycle as key_press.
// Build option: KEY_EVENT_AUTOREPEAT_EN adds the DELAY/REPEAT auto-repeat
// states and frame counter; otherwise a single HELD state is used.
`timescale 1ns/1ps

module key_event_cell
   import key_event_pkg::*;
`ifdef KEY_EVENT_AUTOREPEAT_EN
#(
   parameter int unsigned REPEAT_DELAY = 15,
   parameter int unsigned REPEAT_RATE  = 4
)
`endif
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic frame_tick_i,
   input  logic key_on_i,
   output logic key_held_o,
   output logic key_press_o,
   output logic key_release_o,
   output logic press_next_o
);

   key_state_t state_q, state_d;
   logic       held_q, held_d;
   logic       press_q, press_d;
   logic       release_q, release_d;

`ifdef KEY_EVENT_AUTOREPEAT_EN
   localparam int unsigned      CNT_W     = cnt_width(REPEAT_DELAY, REPEAT_RATE);
   localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE_LOAD = CNT_W'(REPEAT_RATE);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state, counter and pulse decisions; only a frame tick advances the FSM
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      held_d    = held_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (frame_tick_i) begin
         held_d = key_on_i;
         case (state_q)
            IDLE: begin
               if (key_on_i) begin
                  press_d = 1'b1;
                  state_d = DELAY;
                  cnt_d   = DLY_LOAD;
               end else begin
                  state_d = IDLE;
               end
            end
            DELAY: begin
               if (!key_on_i) begin
                  release_d = 1'b1;
                  state_d   = IDLE;
                  cnt_d     = CNT_ZERO;
               end else if (cnt_q == CNT_ONE) begin
                  press_d = 1'b1;
                  state_d = REPEAT;
                  cnt_d   = RATE_LOAD;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            REPEAT: begin
               if (!key_on_i) begin
                  release_d = 1'b1;
                  state_d   = IDLE;
                  cnt_d     = CNT_ZERO;
               end else if (cnt_q == CNT_ONE) begin
                  press_d = 1'b1;
                  cnt_d   = RATE_LOAD;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               // HELD is not used with auto-repeat; recover to IDLE
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end
         endcase
      end else begin
         held_d = held_q;
      end
   end

   // Auto-repeat frame counter
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Next-state and pulse decisions; one press per hold, only on frame ticks
   always_comb begin
      state_d   = state_q;
      held_d    = held_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (frame_tick_i) begin
         held_d = key_on_i;
         case (state_q)
            IDLE: begin
               if (key_on_i) begin
                  press_d = 1'b1;
                  state_d = HELD;
               end else begin
                  state_d = IDLE;
               end
            end
            HELD: begin
               if (!key_on_i) begin
                  release_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  state_d = HELD;
               end
            end
            default: begin
               // DELAY/REPEAT exist only with auto-repeat; recover to IDLE
               state_d = IDLE;
            end
         endcase
      end else begin
         held_d = held_q;
      end
   end
`endif

   // FSM state and registered held/press/release outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         held_q    <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         held_q    <= held_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign key_held_o    = held_q;
   assign key_press_o   = press_q;
   assign key_release_o = release_q;
   assign press_next_o  = press_d;

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: samples NUM_KEYS key levels once per video frame and emits a
// frame-aligned held level, one-cycle press/release pulses and any_press.
// frame_clk is synchronised into Clk and edge-detected into a one-cycle tick.
// Build option: define KEY_EVENT_AUTOREPEAT_EN for fire-style auto-repeat
// (REPEAT_DELAY / REPEAT_RATE in frames); undefined gives one press per hold.
`timescale 1ns/1ps

module key_event_gen
   import key_event_pkg::*;
#(
   parameter int unsigned NUM_KEYS     = 8,
   parameter int unsigned REPEAT_DELAY = 15,
   parameter int unsigned REPEAT_RATE  = 4
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           frame_clk,
   key_event_gen_if.slave bus
);

   // Both repeat intervals are frame counts and must be at least one frame
   if ((REPEAT_DELAY < 32'd1) || (REPEAT_RATE < 32'd1)) begin : g_bad_cfg
      $error("key_event_gen: REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   logic                s1_q, s2_q, s3_q;
   logic                frame_tick_s;
   logic                any_press_q;
   logic [NUM_KEYS-1:0] held_s;
   logic [NUM_KEYS-1:0] press_s;
   logic [NUM_KEYS-1:0] release_s;
   logic [NUM_KEYS-1:0] press_next_s;

   // frame_clk synchroniser plus previous-value flop; reset high so a frame_clk
   // already high at reset release does not produce a tick
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         s3_q <= 1'b1;
      end else begin
         s1_q <= frame_clk;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign frame_tick_s = s2_q & ~s3_q;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_event_cell
`ifdef KEY_EVENT_AUTOREPEAT_EN
      #(
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      )
`endif
      u_cell (
         .clk_i         (Clk),
         .rst_i         (Reset),
         .frame_tick_i  (frame_tick_s),
         .key_on_i      (bus.key_on[i]),
         .key_held_o    (held_s[i]),
         .key_press_o   (press_s[i]),
         .key_release_o (release_s[i]),
         .press_next_o  (press_next_s[i])
      );
   end

   // any_press registered from the same press conditions that load key_press
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         any_press_q <= 1'b0;
      end else begin
         any_press_q <= |press_next_s;
      end
   end

   assign bus.key_held    = held_s;
   assign bus.key_press   = press_s;
   assign bus.key_release = release_s;
   assign bus.any_press   = any_press_q;

endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: scoreboard bench for key_event_gen (REPEAT_DELAY=3,
// REPEAT_RATE=2). Each frame the stimulus side predicts the output event from
// a hold-length model and queues it; a monitor compares every cycle on which
// the DUT shows activity. Honours KEY_EVENT_AUTOREPEAT_EN like the RTL.
`timescale 1ns/1ps

module tb_key_event_gen;
   import key_event_pkg::*;

   localparam int NK = 8;
   localparam int RD = 3;
   localparam int RR = 2;
`ifdef KEY_EVENT_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   localparam int KF = P1_FIRE;

   typedef struct {
      logic [NK-1:0] held;
      logic [NK-1:0] press;
      logic [NK-1:0] rel;
      logic          any;
      int            cyc;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;
   logic frame_clk;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   fire_presses = 0;
   exp_t exp_q[$];
   int   hcnt[NK];
   logic [NK-1:0] m_held;

   key_event_gen_if #(.NUM_KEYS(NK)) bus();

   key_event_gen #(
      .NUM_KEYS     (NK),
      .REPEAT_DELAY (RD),
      .REPEAT_RATE  (RR)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .bus       (bus.slave)
   );

   always #10 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NK; i++) hcnt[i] = 0;
      m_held = '0;
   endtask

   // hcnt[i] = number of consecutive earlier ticks the key was seen held
   task automatic model_tick(input logic [NK-1:0] kon, input int at_cyc);
      exp_t e;
      e.press = '0;
      e.rel   = '0;
      for (int i = 0; i < NK; i++) begin
         if (kon[i]) begin
            if (hcnt[i] == 0) e.press[i] = 1'b1;
            else if (AR && hcnt[i] >= RD && ((hcnt[i] - RD) % RR) == 0) e.press[i] = 1'b1;
            hcnt[i]++;
         end else begin
            if (hcnt[i] > 0) e.rel[i] = 1'b1;
            hcnt[i] = 0;
         end
      end
      e.held = kon;
      e.any  = |e.press;
      e.cyc  = at_cyc;
      if (e.press != '0 || e.rel != '0 || kon != m_held) exp_q.push_back(e);
      m_held = kon;
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // One frame: settle key_on, raise frame_clk, optional mid-frame glitch
   task automatic do_frame(input logic [NK-1:0] kon, input logic [NK-1:0] gmask, input int glen);
      @(negedge Clk);
      bus.key_on = kon;
      wait_neg(5);
      frame_clk = 1'b1;
      model_tick(kon, cyc + 3);
      wait_neg(20);
      frame_clk = 1'b0;
      wait_neg(3);
      if (glen > 0) begin
         bus.key_on = kon ^ gmask;
         wait_neg(glen);
         bus.key_on = kon;
      end
      wait_neg(3);
   endtask

   task automatic monitor();
      logic [NK-1:0] prev_held;
      exp_t e;
      bit   act;
      prev_held = '0;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            prev_held = '0;
         end else begin
            if (bus.key_press[KF]) fire_presses++;
            act = (bus.key_press != '0) || (bus.key_release != '0) || bus.any_press
                  || (bus.key_held != prev_held);
            if (act) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL spurious_event cyc %0d: got held %b press %b rel %b any %b, expected no activity",
                           cyc, bus.key_held, bus.key_press, bus.key_release, bus.any_press);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.key_held !== e.held || bus.key_press !== e.press ||
                      bus.key_release !== e.rel || bus.any_press !== e.any || cyc != e.cyc) begin
                     errors++;
                     $display("FAIL event: got cyc %0d held %b press %b rel %b any %b, expected cyc %0d held %b press %b rel %b any %b",
                              cyc, bus.key_held, bus.key_press, bus.key_release, bus.any_press,
                              e.cyc, e.held, e.press, e.rel, e.any);
                  end
               end
            end
            prev_held = bus.key_held;
         end
      end
   endtask

   initial begin
      logic [NK-1:0] kon;
      logic [NK-1:0] gm;
      int            gl;

      Reset      = 1'b1;
      frame_clk  = 1'b0;
      bus.key_on = '0;
      model_reset();
      fork
         monitor();
      join_none

      // Reset state
      wait_neg(5);
      chk("reset_held",    32'(bus.key_held),    32'd0);
      chk("reset_press",   32'(bus.key_press),   32'd0);
      chk("reset_release", 32'(bus.key_release), 32'd0);
      chk("reset_any",     32'(bus.any_press),   32'd0);
      @(negedge Clk);
      #2 Reset = 1'b0;
      wait_neg(10);

      // Single press with tick latency, then release
      do_frame(8'h01, 8'h00, 0);
      do_frame(8'h00, 8'h00, 0);

      // One-frame tap
      do_frame(8'h02, 8'h00, 0);
      do_frame(8'h00, 8'h00, 0);
      do_frame(8'h00, 8'h00, 0);

      // Auto-repeat on fire key held for nine frames
      fire_presses = 0;
      for (int f = 0; f < 9; f++) do_frame(8'h10, 8'h00, 0);
      do_frame(8'h00, 8'h00, 0);
      wait_neg(5);
      chk("fire_press_count", 32'(fire_presses), AR ? 32'd4 : 32'd1);

      // Simultaneous press of key 2 and release of key 3
      do_frame(8'h08, 8'h00, 0);
      do_frame(8'h08, 8'h00, 0);
      do_frame(8'h04, 8'h00, 0);
      do_frame(8'h00, 8'h00, 0);

      // Intra-frame glitch on key 5 is invisible
      do_frame(8'h00, 8'h20, 100);
      chk("glitch_held5", 32'(bus.key_held[5]), 32'd0);

      // Reset while fire key is repeating
      for (int f = 0; f < 5; f++) do_frame(8'h10, 8'h00, 0);
      chk("held4_before_reset", 32'(bus.key_held[KF]), 32'd1);
      @(negedge Clk);
      #2 Reset = 1'b1;
      #1;
      chk("midreset_held",    32'(bus.key_held),    32'd0);
      chk("midreset_press",   32'(bus.key_press),   32'd0);
      chk("midreset_release", 32'(bus.key_release), 32'd0);
      chk("midreset_any",     32'(bus.any_press),   32'd0);
      model_reset();
      wait_neg(3);
      frame_clk = 1'b1;
      wait_neg(3);
      #2 Reset = 1'b0;
      wait_neg(30);
      frame_clk = 1'b0;
      wait_neg(10);
      do_frame(8'h10, 8'h00, 0);
      do_frame(8'h00, 8'h00, 0);

      // Randomised key levels and glitches
      kon = '0;
      for (int f = 0; f < 60; f++) begin
         for (int i = 0; i < NK; i++) begin
            if ($urandom_range(0, 3) == 0) kon[i] = ~kon[i];
         end
         gm = ($urandom_range(0, 3) == 0) ? NK'($urandom) : '0;
         gl = (gm != '0) ? int'($urandom_range(5, 30)) : 0;
         do_frame(kon, gm, gl);
      end
      do_frame(8'h00, 8'h00, 0);
      wait_neg(10);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
